// File: rtl/kuznechik_pkg.sv
// kuznechik_pkg: shared GOST R 34.12-2015 constants (pi S-box, l coefficients,
// field polynomial) and FSM state encoding for the Kuznechik blocks.
package kuznechik_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] XS    = 3'd1;
    localparam logic [2:0] LSTEP = 3'd2;
    localparam logic [2:0] FINAL = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [8:0] GF_POLY = 9'h1C3;

    // Index 0 multiplies a15, index 15 multiplies a0.
    localparam logic [0:15][7:0] L_COEF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    localparam logic [0:255][7:0] PI = {
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Carry-less product, then fold bits 14..8 back with the field polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--)
            if (p[i]) p ^= 15'(GF_POLY) << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++)
            y[8*i +: 8] = PI[x[8*i +: 8]];
        return y;
    endfunction

endpackage

// File: rtl/kuznechik_r_step.sv
// kuznechik_r_step: one R step of the linear transform, the new state is
// {l(a15..a0), a15..a1}.
module kuznechik_r_step
    import kuznechik_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    logic [7:0] l;

    always_comb begin
        l = '0;
        for (int i = 0; i < 16; i++)
            l ^= gf_mul(din[127-8*i -: 8], L_COEF[i]);
        dout = {l, din[127:8]};
    end

endmodule

// File: rtl/kuznechik_encryptor.sv
// kuznechik_encryptor: iterative Kuznechik block encryption, one XS cycle plus
// sixteen R cycles per round, sharing a single R-step datapath.
module kuznechik_encryptor
    import kuznechik_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] input_word,
    input  logic [127:0] key_1,
    input  logic [127:0] key_2,
    input  logic [127:0] key_3,
    input  logic [127:0] key_4,
    input  logic [127:0] key_5,
    input  logic [127:0] key_6,
    input  logic [127:0] key_7,
    input  logic [127:0] key_8,
    input  logic [127:0] key_9,
    input  logic [127:0] key_10,
    output logic [127:0] output_word,
    output logic         finish
);

    logic [2:0]   st_q, st_d;
    logic [127:0] data_q, data_d, out_q, out_d;
    logic [3:0]   round_q, round_d, step_q, step_d;
    logic         fin_q, fin_d;
    logic [127:0] rk, r_out;

    kuznechik_r_step u_r_step (.din(data_q), .dout(r_out));

    always_comb begin
        case (round_q)
            4'd2:    rk = key_2;
            4'd3:    rk = key_3;
            4'd4:    rk = key_4;
            4'd5:    rk = key_5;
            4'd6:    rk = key_6;
            4'd7:    rk = key_7;
            4'd8:    rk = key_8;
            4'd9:    rk = key_9;
            default: rk = key_1;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        data_d  = data_q;
        out_d   = out_q;
        round_d = round_q;
        step_d  = step_q;
        fin_d   = fin_q;
        case (st_q)
            IDLE: if (enable) begin
                data_d  = input_word;
                round_d = 4'd1;
                st_d    = XS;
            end
            XS: begin
                data_d = sub_bytes(data_q ^ rk);
                step_d = 4'd0;
                st_d   = LSTEP;
            end
            LSTEP: begin
                data_d = r_out;
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    st_d    = (round_q == 4'd9) ? FINAL : XS;
                    round_d = (round_q == 4'd9) ? round_q : round_q + 4'd1;
                end
            end
            FINAL: begin
                out_d = data_q ^ key_10;
                fin_d = 1'b1;
                st_d  = DONE;
            end
            DONE: if (!enable) begin
                fin_d = 1'b0;
                st_d  = IDLE;
            end
            default: st_d = IDLE;
        endcase
        // Dropping enable mid-operation abandons it without touching the output.
        if (!enable && (st_q == XS || st_q == LSTEP || st_q == FINAL)) begin
            st_d  = IDLE;
            out_d = out_q;
            fin_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            data_q  <= '0;
            out_q   <= '0;
            round_q <= '0;
            step_q  <= '0;
            fin_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            data_q  <= data_d;
            out_q   <= out_d;
            round_q <= round_d;
            step_q  <= step_d;
            fin_q   <= fin_d;
        end
    end

    assign output_word = out_q;
    assign finish      = fin_q;

endmodule

// File: tb/tb_kuznechik_encryptor.sv
// tb_kuznechik_encryptor: scoreboard bench; stimulus queues expected ciphertext
// and finish edge, a monitor pops and checks on each rising finish.
module tb_kuznechik_encryptor;
    import kuznechik_pkg::*;

    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [7:0] C [16] = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

    typedef struct {
        logic [127:0] ct;
        int           edge_n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, enable;
    logic [127:0] input_word, output_word;
    logic         finish;
    logic [127:0] k [10];
    logic [127:0] rin, rout;

    exp_t exp_q[$];
    exp_t e_m;
    int   total = 0, bad = 0, cyc = 0;
    logic fin_prev = 1'b0;

    kuznechik_encryptor dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .input_word(input_word),
        .key_1(k[0]), .key_2(k[1]), .key_3(k[2]), .key_4(k[3]), .key_5(k[4]),
        .key_6(k[5]), .key_7(k[6]), .key_8(k[7]), .key_9(k[8]), .key_10(k[9]),
        .output_word(output_word), .finish(finish)
    );

    kuznechik_r_step u_r_alone (.din(rin), .dout(rout));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Shift-and-add multiply, reducing after every doubling.
    function automatic logic [7:0] mmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'hC3) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [127:0] s;
        logic [7:0]   l;
        s = pt;
        for (int r = 0; r < 9; r++) begin
            s ^= k[r];
            for (int j = 0; j < 16; j++) s[8*j +: 8] = PI[s[8*j +: 8]];
            for (int t = 0; t < 16; t++) begin
                l = 8'h00;
                for (int j = 0; j < 16; j++) l ^= mmul(s[127-8*j -: 8], C[j]);
                s = {l, s[127:8]};
            end
        end
        return s ^ k[9];
    endfunction

    always @(negedge clk) begin
        if (finish && !fin_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_finish: got finish=1 want no finish at edge %0d", cyc);
            end else begin
                e_m = exp_q.pop_front();
                chk("ciphertext", output_word, e_m.ct);
                chk("latency_edge", 128'(cyc), 128'(e_m.edge_n));
            end
        end
        fin_prev <= finish;
    end

    task automatic wait_finish(input string nm);
        int n;
        n = 0;
        while (!finish && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!finish) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got finish=0 want finish=1 within 400 cycles", nm);
        end
    endtask

    // Called at a negedge; enable is sampled at the next posedge.
    task automatic run_enc(input logic [127:0] pt, input logic [127:0] ct, input string nm);
        exp_t e;
        enable     = 1'b1;
        input_word = pt;
        e.ct       = ct;
        e.edge_n   = cyc + 155;
        exp_q.push_back(e);
        @(negedge clk);
        input_word = ~pt;
        wait_finish(nm);
    endtask

    initial begin
        logic         seen;
        logic [127:0] pt, ct;
        exp_t         e;
        k[0] = 128'h8899aabbccddeeff0011223344556677;
        k[1] = 128'hfedcba98765432100123456789abcdef;
        k[2] = 128'hdb31485315694343228d6aef8cc78c44;
        k[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
        k[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
        k[5] = 128'hbd079435165c6432b532e82834da581b;
        k[6] = 128'h51e640757e8745de705727265a0098b1;
        k[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
        k[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
        k[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
        rst_n      = 1'b0;
        enable     = 1'b1;
        input_word = PT;
        rin        = '0;
        repeat (3) @(negedge clk);
        chk("reset_output_word", output_word, '0);
        chk("reset_finish", 128'(finish), '0);
        enable = 1'b0;
        rst_n  = 1'b1;

        rin = 128'h00000000000000000000000000000100;
        #1 chk("r_step_vec", rout, 128'h94000000000000000000000000000001);
        rin = 128'h00000000000000000000000000000001;
        #1 chk("r_step_a0", rout, 128'h01000000000000000000000000000000);
        chk("s_vec", sub_bytes(128'hffeeddccbbaa99881122334455667700), 128'hb66cd8887d38e8d77765aeea0c9a7efc);

        repeat (2) @(negedge clk);
        chk("idle_no_finish", 128'(finish), '0);

        run_enc(PT, CT, "enc_ref");
        repeat (50) begin
            @(negedge clk);
            chk("hold_finish", 128'(finish), 128'd1);
            chk("hold_output", output_word, CT);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("drop_finish", 128'(finish), '0);
        repeat (5) @(negedge clk);
        chk("no_restart", 128'(finish), '0);
        chk("idle_output_kept", output_word, CT);

        enable     = 1'b1;
        input_word = 128'h0123456789abcdef0011223344556677;
        repeat (80) @(negedge clk);
        enable = 1'b0;
        seen   = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (finish) seen = 1'b1;
        end
        chk("abort_no_finish", 128'(seen), '0);
        chk("abort_output_kept", output_word, CT);
        run_enc(PT, CT, "enc_after_abort");
        enable = 1'b0;
        @(negedge clk);

        enable     = 1'b1;
        input_word = PT;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midop_reset_output", output_word, '0);
        chk("midop_reset_finish", 128'(finish), '0);
        rst_n    = 1'b1;
        e.ct     = CT;
        e.edge_n = cyc + 155;
        exp_q.push_back(e);
        wait_finish("enc_after_reset");
        enable = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = model_enc(pt);
            run_enc(pt, ct, "enc_random");
            enable = 1'b0;
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kuznechik_encryptor.md
KUZNECHIK_ENCRYPTOR -- requirements
Module: kuznechik_encryptor

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and SHALL be the single rising-edge clock for all state.
REQ-002 The port rst_n SHALL be an input, 1 bit wide, and SHALL be the synchronous, active-low reset.
REQ-003 The port enable SHALL be an input, 1 bit wide, and SHALL be a level request to encrypt input_word, held high by the master until finish is seen.
REQ-004 The port input_word SHALL be an input, 128 bits wide, carrying the plaintext; bits 127:120 are byte a15.
REQ-005 The ports key_1..key_10 SHALL each be inputs, 128 bits wide, carrying the precomputed round keys K1..K10, which are stable while enable is high.
REQ-006 The port output_word SHALL be an output register, 128 bits wide, carrying the ciphertext.
REQ-007 The port finish SHALL be an output register, 1 bit wide, asserted high while output_word is valid.

Function
REQ-008 Encryption SHALL compute E = X[K10] LSX[K9] ... LSX[K1], per GOST R 34.12-2015.
REQ-009 X[k] SHALL be a 128-bit XOR; S SHALL apply the pi S-box to each of the 16 bytes independently.
REQ-010 L SHALL be 16 successive R steps; R(a15..a0) = l(a15..a0) || a15..a1, so the new state is {l, state[127:8]}.
REQ-011 l SHALL be the GF(2^8) sum, modulo x^8+x^7+x^6+x+1 (0x1C3), with coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1 applied to a15..a0.
REQ-012 The block SHALL use the states IDLE, XS, LSTEP, FINAL and DONE, with a 4-bit round counter (1..9) and a 4-bit step counter (0..15).
REQ-013 In IDLE with enable=1, the block SHALL load state<=input_word, set round<=1, and go to XS; in IDLE with enable=0, it SHALL hold.
REQ-014 In XS, the block SHALL set state<=S(state^K[round]), set step<=0, and go to LSTEP.
REQ-015 In LSTEP, the block SHALL set state<=R(state) and step<=step+1; at step 15, it SHALL go to FINAL if round=9, otherwise set round<=round+1 and go to XS.
REQ-016 In FINAL, the block SHALL set output_word<=state^K10 and finish<=1, and go to DONE.
REQ-017 In DONE, the block SHALL hold output_word and finish while enable=1; on enable=0 it SHALL clear finish and go to IDLE, and SHALL NOT restart in that same cycle.
REQ-018 Latency: finish SHALL rise 154 clock edges after the edge that samples enable high in IDLE (1 load, 9x17 round cycles, 1 final), with no variation.
REQ-019 If enable=0 in XS, LSTEP or FINAL, the operation SHALL abort: next state IDLE, finish stays 0, and output_word keeps its previous value.
REQ-020 input_word SHALL be sampled only in IDLE; changes on input_word afterwards SHALL NOT affect the result.
REQ-021 Keys SHALL be read combinationally each XS/FINAL cycle; the block SHALL NOT copy them into internal registers.

Reset
REQ-022 When rst_n=0 at a rising edge, the block SHALL set state to IDLE, finish<=0, output_word<=0, round<=0, step<=0 and the data register to 0.
REQ-023 Reset SHALL override enable and any in-flight operation, including when it arrives mid-round; after rst_n returns to 1, the block SHALL start only on a new enable sampled in IDLE.

Structure
REQ-024 Package kuznechik_pkg SHALL hold the pi S-box table (256x8), the l coefficient array, the GF polynomial constant 0x1C3, and the FSM state encoding, shared with the existing key-schedule and decryption blocks.
REQ-025 A single combinational sub-module, kuznechik_r_step, SHALL implement R (128-bit in/out) together with its GF(2^8) multiplies; the encryptor SHALL instantiate it exactly once.

Verification
REQ-026 With K1..K10 = 8899aabbccddeeff0011223344556677, fedcba98765432100123456789abcdef, db31485315694343228d6aef8cc78c44, 3d4553d8e9cfec6815ebadc40a9ffd04, 57646468c44a5e28d3e59246f429f1ac, bd079435165c6432b532e82834da581b, 51e640757e8745de705727265a0098b1, 5a7925017b9fdd3ed72a91a22286f984, bb44e25378c73123a5f32f73cdb6e517, 72e9dd7416bcf45b755dbaa88e4a4043 and plaintext 1122334455667700ffeeddccbbaa9988, the bench SHALL check output_word=7f679d90bebc24305a468d42b9d4edcd with finish rising exactly 154 edges after enable.
REQ-027 The bench SHALL drive kuznechik_r_step alone with 00000000000000000000000000000100 and check 94000000000000000000000000000001; it SHALL also check S(ffeeddccbbaa99881122334455667700)=b66cd8887d38e8d77765aeea0c9a7efc.
REQ-028 The bench SHALL hold enable high for 50 cycles after finish and check that finish and output_word hold; it SHALL then drop enable and check finish=0 on the next edge, with no restart until enable rises again.
REQ-029 The bench SHALL drop enable at cycle 80 and check that finish never asserts and output_word is unchanged; a fresh enable SHALL then yield the REQ-026 ciphertext in 154 edges.
REQ-030 The bench SHALL assert rst_n=0 for 1 cycle at cycle 100 of an operation and check output_word=0 and finish=0; with enable held high through reset, the next encryption SHALL complete correctly.
REQ-031 The bench SHALL run back-to-back encryptions (enable dropped for 1 cycle between them) on random plaintexts and check each result against a software model.
